// File: rtl/dmem_arbiter_if.sv
// Requester-side bundle for one data-memory port: request/handshake towards the
// arbiter and the registered read response back.
interface dmem_arbiter_if #(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned BE_WIDTH   = 4
);
    logic                  req;
    logic                  we;
    logic [BE_WIDTH-1:0]   be;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  gnt;
    logic                  rvalid;
    logic [DATA_WIDTH-1:0] rdata;

    modport master (
        output req, we, be, addr, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, be, addr, wdata,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Shares one data BRAM port between the CPU (fixed priority) and a debug/loader
// port; a saturating wait counter forces a debug grant after MAX_WAIT denials.
module dmem_arbiter #(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned BE_WIDTH   = 4,
    parameter int unsigned MAX_WAIT   = 4
) (
    input  logic                  sysclk_i,
    input  logic                  rst_ni,
    dmem_arbiter_if.slave         cpu_if,
    dmem_arbiter_if.slave         dbg_if,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    output logic [BE_WIDTH-1:0]   mem_be_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i
);
    localparam int unsigned CntWidth = $clog2(MAX_WAIT + 1);
    localparam logic [CntWidth-1:0] CntMax = CntWidth'(MAX_WAIT);

    typedef enum logic [1:0] {OwnNone, OwnCpu, OwnDbg} owner_e;

    logic                  cpu_gnt;
    logic                  dbg_gnt;
    logic [CntWidth-1:0]   wait_cnt_q, wait_cnt_d;
    owner_e                rd_owner_q, rd_owner_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;

    // Grants are held low during reset so nothing reaches the BRAM.
    always_comb begin
        cpu_gnt = 1'b0;
        dbg_gnt = 1'b0;
        if (rst_ni) begin
            if (cpu_if.req && dbg_if.req) begin
                if (wait_cnt_q == CntMax) dbg_gnt = 1'b1;
                else                      cpu_gnt = 1'b1;
            end else if (cpu_if.req) begin
                cpu_gnt = 1'b1;
            end else if (dbg_if.req) begin
                dbg_gnt = 1'b1;
            end
        end
    end

    always_comb begin
        wait_cnt_d = '0;
        if (dbg_if.req && !dbg_gnt) begin
            wait_cnt_d = (wait_cnt_q == CntMax) ? CntMax : wait_cnt_q + 1'b1;
        end
    end

    // Address/wdata hold their last value when idle; only byte enables gate writes.
    always_comb begin
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_o    = '0;
        rd_owner_d  = OwnNone;
        if (cpu_gnt) begin
            mem_addr_d  = cpu_if.addr;
            mem_wdata_d = cpu_if.wdata;
            if (cpu_if.we) mem_be_o   = cpu_if.be;
            else           rd_owner_d = OwnCpu;
        end else if (dbg_gnt) begin
            mem_addr_d  = dbg_if.addr;
            mem_wdata_d = dbg_if.wdata;
            if (dbg_if.we) mem_be_o   = dbg_if.be;
            else           rd_owner_d = OwnDbg;
        end
    end

    always_ff @(posedge sysclk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wait_cnt_q  <= '0;
            rd_owner_q  <= OwnNone;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            wait_cnt_q  <= wait_cnt_d;
            rd_owner_q  <= rd_owner_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign mem_addr_o  = mem_addr_d;
    assign mem_wdata_o = mem_wdata_d;

    assign cpu_if.gnt    = cpu_gnt;
    assign cpu_if.rvalid = (rd_owner_q == OwnCpu);
    assign cpu_if.rdata  = mem_rdata_i;
    assign dbg_if.gnt    = dbg_gnt;
    assign dbg_if.rvalid = (rd_owner_q == OwnDbg);
    assign dbg_if.rdata  = mem_rdata_i;
endmodule
